tdm_demux_4ch: RTL and testbench

- Time-division demultiplexer and frame collector for the 4-to-1 mux datapath.
- Drives the select lines of an upstream combinational 4:1 mux and samples its output once per slot.
- Reassembles the four channel words into a parallel frame and publishes each complete frame with a one-cycle valid pulse.
- Sits after the mux as the receiving end of the mux-shared bus.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/mux_4to1.sv | 30 +++
 rtl/tdm_demux_4ch.sv | 128 ++++++++++++
 tb/tb_tdm_demux_4ch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4-channel TDM receive path.
//   NUM_CH      : number of time slots per frame
//   sel_t       : slot select type driven to the upstream mux
//   tdm_state_t : collector FSM states
// -----------------------------------------------------------------------------
package tdm_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/mux_4to1.sv
// -----------------------------------------------------------------------------
// mux_4to1
// Combinational 4:1 word mux that shares one bus between four sources.
// Ports:
//   d0..d3 : source words
//   sel    : source select
//   y      : selected word
// -----------------------------------------------------------------------------
module mux_4to1 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
// Receiving end of a mux-shared bus. Steps the upstream mux select through
// slots 0..3, samples the mux output once per slot and publishes each
// complete frame as four parallel words with a one-cycle valid pulse.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   en          : scan enable, high runs back-to-back frames
//   y_in        : mux output, valid in the same cycle as sel
//   sel         : slot select to the upstream mux
//   d0..d3      : channel words of the last complete frame
//   frame_valid : one-cycle pulse when d0..d3 update
//   busy        : high while scanning
//   frame_cnt   : completed frame count, wraps at 256
// -----------------------------------------------------------------------------
module tdm_demux_4ch
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] y_in,
   output sel_t             sel,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic             frame_valid,
   output logic             busy,
   output logic [7:0]       frame_cnt
);

   tdm_state_t       state_reg, state_next;
   sel_t             sel_reg, sel_next;
   // Slots 0..2 are held here until the last slot arrives, so the ports
   // only ever show a complete frame.
   logic [WIDTH-1:0] shadow_reg [0:NUM_CH-2];
   logic [WIDTH-1:0] shadow_next[0:NUM_CH-2];
   logic [WIDTH-1:0] dout_reg   [0:NUM_CH-1];
   logic [WIDTH-1:0] dout_next  [0:NUM_CH-1];
   logic             fv_reg, fv_next;
   logic             busy_reg;
   logic [7:0]       cnt_reg, cnt_next;

   always_comb begin
      state_next  = state_reg;
      sel_next    = sel_reg;
      shadow_next = shadow_reg;
      dout_next   = dout_reg;
      fv_next     = 1'b0;
      cnt_next    = cnt_reg;

      case (state_reg)
         IDLE: begin
            sel_next = '0;
            // The entry edge only arms the scan; slot 0 is sampled next edge.
            if (en) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (!en) begin
               // Abort: the partial frame in the shadow bank is simply
               // abandoned; a restart always overwrites it from slot 0.
               state_next = IDLE;
               sel_next   = '0;
            end else if (sel_reg == sel_t'(NUM_CH - 1)) begin
               for (int i = 0; i < NUM_CH - 1; i++) begin
                  dout_next[i] = shadow_reg[i];
               end
               dout_next[NUM_CH-1] = y_in;
               fv_next             = 1'b1;
               cnt_next            = cnt_reg + 8'd1;
               sel_next            = '0;
            end else begin
               for (int i = 0; i < NUM_CH - 1; i++) begin
                  if (sel_reg == sel_t'(i)) begin
                     shadow_next[i] = y_in;
                  end
               end
               sel_next = sel_t'(sel_reg + 2'd1);
            end
         end
         default: begin
            state_next = IDLE;
            sel_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         for (int i = 0; i < NUM_CH - 1; i++) begin
            shadow_reg[i] <= '0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            dout_reg[i] <= '0;
         end
         fv_reg    <= 1'b0;
         busy_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         sel_reg    <= sel_next;
         shadow_reg <= shadow_next;
         dout_reg   <= dout_next;
         fv_reg     <= fv_next;
         // Registered copy of the state decode keeps busy glitch-free.
         busy_reg   <= (state_next == SCAN);
         cnt_reg    <= cnt_next;
      end
   end

   assign sel         = sel_reg;
   assign d0          = dout_reg[0];
   assign d1          = dout_reg[1];
   assign d2          = dout_reg[2];
   assign d3          = dout_reg[3];
   assign frame_valid = fv_reg;
   assign busy        = busy_reg;
   assign frame_cnt   = cnt_reg;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_4ch
// Self-checking bench: tdm_demux_4ch receiving from mux_4to1. A frame-level
// reference model (a queue of captured words) predicts every output after
// every clock edge; table records and hand-written sequences add explicit
// checks for the listed corner cases.
// -----------------------------------------------------------------------------
module tb_tdm_demux_4ch;
   import tdm_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en = 1'b0;
   logic [W-1:0] src [0:3];
   logic [W-1:0] y;
   sel_t         sel;
   logic [W-1:0] d0, d1, d2, d3;
   logic         frame_valid, busy;
   logic [7:0]   frame_cnt;

   int errors = 0;
   int checks = 0;

   // reference model: scanning flag, words captured so far in this frame
   bit           m_scan;
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_d[4];
   bit           m_fv;
   int           m_cnt;

   typedef struct {
      logic [15:0] src_w;   // {s3,s2,s1,s0}
      logic [15:0] exp_w;   // {d3,d2,d1,d0}
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   mux_4to1 #(.WIDTH(W)) u_mux (
      .d0 (src[0]),
      .d1 (src[1]),
      .d2 (src[2]),
      .d3 (src[3]),
      .sel(sel),
      .y  (y)
   );

   tdm_demux_4ch #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .y_in       (y),
      .sel        (sel),
      .d0         (d0),
      .d1         (d1),
      .d2         (d2),
      .d3         (d3),
      .frame_valid(frame_valid),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_scan = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_d[i] = '0;
      m_fv  = 0;
      m_cnt = 0;
   endfunction

   function automatic int model_sel();
      return m_scan ? m_q.size() : 0;
   endfunction

   // Advance the model by one clock edge using the inputs present before it.
   function automatic void model_edge();
      logic [W-1:0] word;
      word = src[model_sel()];
      m_fv = 0;
      if (!m_scan) begin
         if (en) begin
            m_scan = 1;
            m_q.delete();
         end
      end else if (!en) begin
         m_scan = 0;
         m_q.delete();
      end else begin
         m_q.push_back(word);
         if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_d[i] = m_q[i];
            m_q.delete();
            m_fv  = 1;
            m_cnt = (m_cnt + 1) % 256;
         end
      end
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_sel"},  32'(sel),         32'(model_sel()));
      chk({tag, "_d0"},   32'(d0),          32'(m_d[0]));
      chk({tag, "_d1"},   32'(d1),          32'(m_d[1]));
      chk({tag, "_d2"},   32'(d2),          32'(m_d[2]));
      chk({tag, "_d3"},   32'(d3),          32'(m_d[3]));
      chk({tag, "_fv"},   32'(frame_valid), 32'(m_fv));
      chk({tag, "_busy"}, 32'(busy),        32'(m_scan));
      chk({tag, "_cnt"},  32'(frame_cnt),   32'(m_cnt));
   endtask

   task automatic step(input logic en_v, input string tag);
      en = en_v;
      model_edge();
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic set_src(input logic [15:0] w);
      for (int i = 0; i < 4; i++) src[i] = w[i*4 +: 4];
   endtask

   task automatic async_reset_pulse();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_sel", 32'(sel), 0);
      chk("arst_d",   32'({d3, d2, d1, d0}), 0);
      chk("arst_fv",  32'(frame_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cnt", 32'(frame_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] prev;
      tbl[0] = '{16'b1111_0110_1010_1110, 16'b1111_0110_1010_1110};
      tbl[1] = '{16'b1000_0100_0010_0001, 16'b1000_0100_0010_0001};
      tbl[2] = '{16'h0000,                16'h0000};
      tbl[3] = '{16'hFFFF,                16'hFFFF};
      tbl[4] = '{16'h5A3C,                16'h5A3C};
      set_src(16'h0000);
      model_reset();

      // reset asserted mid-cycle before any clock edge
      #3 rst_n = 1'b0;
      #1;
      chk("init_sel", 32'(sel), 0);
      chk("init_d",   32'({d3, d2, d1, d0}), 0);
      chk("init_fv",  32'(frame_valid), 0);
      chk("init_busy", 32'(busy), 0);
      chk("init_cnt", 32'(frame_cnt), 0);
      repeat (2) @(posedge clk);
      #1 check_outputs("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0, "idle");

      // single frames from the table: entry edge + 4 capture edges
      for (int t = 0; t < 5; t++) begin
         set_src(tbl[t].src_w);
         for (int k = 0; k < 5; k++) begin
            chk("tbl_fv_early", 32'(frame_valid), 0);
            step(1'b1, "tbl");
         end
         chk("tbl_fv", 32'(frame_valid), 1);
         chk("tbl_frame", 32'({d3, d2, d1, d0}), 32'(tbl[t].exp_w));
         chk("tbl_cnt", 32'(frame_cnt), 32'(t + 1));
         step(1'b0, "tbl_end");
         chk("tbl_idle_sel", 32'(sel), 0);
      end

      // continuous frames, sources changed between frames
      async_reset_pulse();
      step(1'b1, "cont_entry");
      for (int f = 0; f < 3; f++) begin
         set_src(tbl[f].src_w);
         for (int k = 0; k < 4; k++) step(1'b1, "cont");
         chk("cont_fv", 32'(frame_valid), 1);
         chk("cont_frame", 32'({d3, d2, d1, d0}), 32'(tbl[f].exp_w));
      end
      chk("cont_cnt", 32'(frame_cnt), 3);

      // abort at sel=2, then restart from slot 0
      prev = {d3, d2, d1, d0};
      set_src(16'h1234);
      step(1'b1, "abort");
      step(1'b1, "abort");
      chk("abort_sel2", 32'(sel), 2);
      step(1'b0, "abort_drop");
      chk("abort_keep", 32'({d3, d2, d1, d0}), 32'(prev));
      chk("abort_sel0", 32'(sel), 0);
      chk("abort_fv", 32'(frame_valid), 0);
      step(1'b0, "abort_idle");
      set_src(16'h9ABC);
      for (int k = 0; k < 5; k++) step(1'b1, "restart");
      chk("restart_frame", 32'({d3, d2, d1, d0}), 32'h9ABC);
      chk("restart_cnt", 32'(frame_cnt), 4);
      step(1'b0, "restart_end");

      // async reset while sel=3, then resume with en high
      set_src(16'hCAFE);
      for (int k = 0; k < 4; k++) step(1'b1, "pre_arst");
      chk("pre_arst_sel3", 32'(sel), 3);
      async_reset_pulse();
      set_src(16'h7E81);
      for (int k = 0; k < 5; k++) step(1'b1, "post_arst");
      chk("post_arst_fv", 32'(frame_valid), 1);
      chk("post_arst_frame", 32'({d3, d2, d1, d0}), 32'h7E81);
      chk("post_arst_cnt", 32'(frame_cnt), 1);
      step(1'b0, "post_arst_end");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 4; c++) src[c] = W'($urandom_range(0, 15));
         step(($urandom_range(0, 7) != 0), "rand");
      end
      step(1'b0, "rand_end");

      // 256 back-to-back frames: counter wraps to 0 on the last one
      async_reset_pulse();
      step(1'b1, "wrap_entry");
      for (int f = 0; f < 256; f++) begin
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) src[c] = W'($urandom_range(0, 15));
            step(1'b1, "wrap");
         end
         if (f == 254) chk("wrap_cnt255", 32'(frame_cnt), 255);
      end
      chk("wrap_cnt0", 32'(frame_cnt), 0);
      chk("wrap_fv", 32'(frame_valid), 1);
      step(1'b0, "wrap_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
